// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops, plus an iterative shift-add multiplier.
// Each result is held with a valid/ready handshake until the consumer takes it.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       flags
);

   localparam int              CNT_W  = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]  ONE_W  = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH:0]  W_AMT  = (WIDTH+1)'(WIDTH);
   localparam logic [3:0]      OP_MUL = 4'b0111;

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

   state_t               state;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_next;
   logic [WIDTH-1:0]     mplier;
   logic [CNT_W-1:0]     cnt;
   logic [WIDTH+3:0]     alu_res;

   // Single-cycle ops. Returns {N,V,C,Z,result}; MUL and unused codes give zero.
   function automatic logic [WIDTH+3:0] alu_eval(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [3:0]       code);
      logic [WIDTH:0]          wide;
      logic [WIDTH:0]          amt;
      logic [WIDTH-1:0]        r;
      logic [WIDTH-1:0]        sh;
      logic signed [WIDTH-1:0] sx;
      logic signed [WIDTH-1:0] sy;
      logic signed [WIDTH-1:0] sr;
      logic                    c;
      logic                    v;
      logic                    shift_ok;
      wide     = '0;
      r        = '0;
      sh       = '0;
      c        = 1'b0;
      v        = 1'b0;
      amt      = {1'b0, y};
      // The last bit shifted out only exists for shift amounts 1..WIDTH
      shift_ok = (amt != '0) && (amt <= W_AMT);
      sx       = x;
      sy       = y;
      case (code)
         4'b0000: begin
            wide = {1'b0, x} + {1'b0, y};
            r    = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            sr   = r;
            v    = (sx[WIDTH-1] == sy[WIDTH-1]) && (sr[WIDTH-1] != sx[WIDTH-1]);
         end
         4'b0001: begin
            // Carry out of a + ~b + 1 is the inverted borrow
            wide = {1'b0, x} + {1'b0, ~y} + ONE_W;
            r    = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            sr   = r;
            v    = (sx[WIDTH-1] != sy[WIDTH-1]) && (sr[WIDTH-1] != sx[WIDTH-1]);
         end
         4'b0010: r = x & y;
         4'b0011: r = x | y;
         4'b0100: r = x ^ y;
         4'b0101: begin
            r  = (amt >= W_AMT) ? '0 : (x << y);
            sh = x << (y - ONE);
            c  = shift_ok ? sh[WIDTH-1] : 1'b0;
         end
         4'b0110: begin
            r  = (amt >= W_AMT) ? '0 : (x >> y);
            sh = x >> (y - ONE);
            c  = shift_ok ? sh[0] : 1'b0;
         end
         default: r = '0;
      endcase
      return {r[WIDTH-1], v, c, (r == '0), r};
   endfunction

   assign alu_res  = alu_eval(a, b, op);
   assign in_ready = (state == IDLE);

   // Next partial product: add the shifted multiplicand when the multiplier LSB is set
   always_comb begin
      acc_next = acc + (mplier[0] ? mcand : '0);
   end

   // Control FSM, multiplier datapath and registered result/flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out       <= '0;
         flags     <= '0;
         out_valid <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (op == OP_MUL) begin
                     mcand  <= {{WIDTH{1'b0}}, a};
                     mplier <= b;
                     acc    <= '0;
                     cnt    <= '0;
                     state  <= MUL;
                  end else begin
                     {flags, out} <= alu_res;
                     out_valid    <= 1'b1;
                     state        <= HOLD;
                  end
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  out       <= acc_next[WIDTH-1:0];
                  flags     <= {acc_next[WIDTH-1], 1'b0,
                                (acc_next[2*WIDTH-1:WIDTH] != '0),
                                (acc_next[WIDTH-1:0] == '0)};
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8) with hand-computed expected values.
module tb_seq_alu;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic [3:0] flags;

   int n_chk  = 0;
   int n_fail = 0;

   seq_alu #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one request at a negedge; returns at the negedge after the accept edge
   task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] top);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_in_ready", in_ready, 1);
      a = ta; b = tb; op = top; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = 8'h00; b = 8'h00; op = 4'h0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("consume_valid", out_valid, 0);
      chk("consume_ready", in_ready, 1);
   endtask

   task automatic alu_case(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                           input logic [3:0] top, input logic [7:0] eo, input logic [3:0] ef);
      send(ta, tb, top);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_out"}, out, eo);
      chk({tag, "_flags"}, flags, ef);
      chk({tag, "_in_ready"}, in_ready, 0);
      consume();
   endtask

   task automatic mul_case(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                           input logic [7:0] eo, input logic [3:0] ef);
      send(ta, tb, 4'b0111);
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_busy_valid"}, out_valid, 0);
         chk({tag, "_busy_ready"}, in_ready, 0);
         @(negedge clk);
      end
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_out"}, out, eo);
      chk({tag, "_flags"}, flags, ef);
      consume();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      a = 8'h03; b = 8'h04; op = 4'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out", out, 8'h00);
      chk("rst_flags", flags, 4'h0);

      // flags are {N,V,C,Z}
      alu_case("add_ff_01", 8'hFF, 8'h01, 4'b0000, 8'h00, 4'b0011);
      alu_case("add_ovf",   8'h7F, 8'h01, 4'b0000, 8'h80, 4'b1100);
      alu_case("sub_80_01", 8'h80, 8'h01, 4'b0001, 8'h7F, 4'b0110);
      alu_case("sub_borrow",8'h01, 8'h02, 4'b0001, 8'hFF, 4'b1000);
      alu_case("op_f",      8'h55, 8'h33, 4'b1111, 8'h00, 4'b0001);
      alu_case("and",       8'hF0, 8'h3C, 4'b0010, 8'h30, 4'b0000);
      alu_case("or",        8'hF0, 8'h0F, 4'b0011, 8'hFF, 4'b1000);
      alu_case("xor",       8'hAA, 8'hAA, 4'b0100, 8'h00, 4'b0001);
      alu_case("shl_1",     8'h81, 8'h01, 4'b0101, 8'h02, 4'b0010);
      alu_case("shr_8",     8'h81, 8'h08, 4'b0110, 8'h00, 4'b0011);
      alu_case("shl_9",     8'h81, 8'h09, 4'b0101, 8'h00, 4'b0001);
      alu_case("shr_0",     8'h81, 8'h00, 4'b0110, 8'h81, 4'b1000);
      mul_case("mul_10_11", 8'h10, 8'h11, 8'h10, 4'b0010);
      mul_case("mul_ff_ff", 8'hFF, 8'hFF, 8'h01, 4'b0010);
      mul_case("mul_03_05", 8'h03, 8'h05, 8'h0F, 4'b0000);

      // Backpressure: result held, new requests ignored while waiting
      send(8'h12, 8'h34, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         a = 8'hFF; b = 8'hFF; op = 4'b0000; in_valid = i[0];
         chk("bp_valid", out_valid, 1);
         chk("bp_out", out, 8'h46);
         chk("bp_flags", flags, 4'b0000);
         chk("bp_in_ready", in_ready, 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp_end_out", out, 8'h46);
      consume();
      @(negedge clk);
      chk("bp_idle_out", out, 8'h46);
      chk("bp_idle_valid", out_valid, 0);

      // Reset on the third multiply cycle discards the product
      send(8'h10, 8'h11, 4'b0111);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_out", out, 8'h00);
      chk("mrst_flags", flags, 4'h0);
      chk("mrst_in_ready", in_ready, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("mrst_no_result", out_valid, 0);
      end
      alu_case("add_03_04", 8'h03, 8'h04, 4'b0000, 8'h07, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule
